mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one byte-wide external memory bus between the instruction-side cache (port 0) and the data-side cache (port 1) of the 5-stage core.
- Sits between the two cache miss/fill interfaces and the memory controller.
- Grants one requester at a time.
- Serialises 1–4 byte transfers one byte per cycle, little-endian.
- Returns assembled read data with a one-cycle done pulse.

Parameters:
ADDR_W, 32, address width per requester and on the memory bus
RD_LAT, 1, memory read latency in cycles from mem_a to valid mem_din (1..3)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset, asynchronous, active-high
req  input  2  per-port request, bit i = port i; held until done[i]
we  input  2  per-port write enable (1=write, 0=read)
addr  input  2*ADDR_W  per-port byte base address, port i at [i*ADDR_W +: ADDR_W]
len  input  4  per-port length, port i at [2i+1:2i]; bytes = len+1
wdata  input  64  per-port write data, port i at [32i +: 32], byte k at bits [8k+7:8k]
gnt  output  2  one-cycle pulse, first cycle of the granted transfer
done  output  2  one-cycle pulse, transfer complete (rdata valid for reads)
rdata  output  32  read data of the last completed read, zero-extended
mem_a  output  ADDR_W  memory byte address
mem_dout  output  8  memory write byte
mem_wr  output  1  memory write strobe
mem_din  input  8  memory read byte, valid RD_LAT cycles after its mem_a

Behaviour:
- Reset values: gnt=0, done=0, rdata=0, mem_a=0, mem_dout=0, mem_wr=0, state=IDLE, last=1.
- Reset mid-transfer aborts at once: mem_wr drops asynchronously, no done is issued, and latched data is discarded.
- States:
  - IDLE→ADDR when any req bit is sampled high.
  - ADDR→DRAIN for a read after the last byte address.
  - ADDR→DONE for a write after the last byte.
  - DRAIN→DONE after the last byte is captured.
  - DONE→IDLE unconditionally.
- Latching: at the IDLE→ADDR edge, latch winner id, we, addr, len and wdata; the byte counter k=0. Later input changes are ignored until DONE.
- Sample timing: req sampled high at end of cycle 0 gives, in cycle 1, gnt[winner]=1, mem_a=addr, and (for writes) mem_wr=1 with mem_dout=wdata byte 0.
- ADDR state: drive mem_a=addr+k, modulo 2^ADDR_W (wraps at all-ones). Writes drive mem_wr=1 and mem_dout=byte k; reads drive mem_wr=0. k increments each cycle until k==len.
- Read capture: mem_din for byte k is captured RD_LAT cycles after byte k's address cycle into rdata[8k+7:8k]. rdata is cleared to 0 at grant, so bytes above len stay 0. DRAIN lasts RD_LAT cycles, with mem_wr=0 and mem_a holding its last value.
- DONE: done[winner]=1 for exactly one cycle; rdata is stable from this cycle until the next grant. mem_wr=0.
- Latency with N=len+1 bytes:
  - Write: gnt in cycle 1, done in cycle N+1.
  - Read: gnt in cycle 1, done in cycle N+RD_LAT+1.
- Back-to-back: a req still high in the DONE cycle is sampled in the following IDLE cycle, giving the next gnt 2 cycles after done. There is no arbitration during ADDR/DRAIN/DONE.
- Arbitration for a single request: the requester is granted.
- Arbitration for a simultaneous request: resolved per the Optional Feature. `last` updates to the winner at each grant.
- Never both gnt bits, never both done bits, and never gnt and done in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin; on simultaneous requests the port != last wins, so port 0 wins the first tie after reset.
- Undefined: fixed priority, port 1 (data) always wins ties. The `last` register is still kept but ignored.

Test Plan:
- Single write: port1 req, we=1, addr=0x100, len=3, wdata=0xDDCCBBAA → cycles 1–4 mem_a=0x100..0x103, mem_dout=AA,BB,CC,DD, mem_wr=1; gnt[1] in cycle 1, done[1] in cycle 5.
- Read: port0 read, addr=0x200, len=1, RD_LAT=1, memory returns 0x34 then 0x12 → done[0] in cycle 4, rdata=0x00001234. Repeat with RD_LAT=3 → done in cycle 6.
- Tie in the same cycle, both ports:
  - With MEM_ARB_RR_EN: port0 granted first, then port1 two cycles after done[0]; with both held high, grants alternate 0,1,0.
  - Without the macro: port1 wins every tie.
- Address wrap: read addr=0xFFFFFFFE, len=3 → mem_a=FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset mid-write: rst asserted in cycle 2 of a 4-byte write → mem_wr=0 immediately, no done, gnt=0. After release, a new req gets its grant with timing as from reset.
- Late request: port0 requests while port1 is in ADDR → no gnt[0] until port1's DONE+1; port0 inputs changed during port1's transfer do not affect the bus.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester/memory bus bundle for mem_port_arbiter
// Ports (slave = arbiter side):
//   req[1:0], we[1:0]     per-port request and write enable (port 0 = icache, port 1 = dcache)
//   addr[2*ADDR_W-1:0]    per-port byte base address, port i at [i*ADDR_W +: ADDR_W]
//   len[3:0]              per-port length, port i at [2i+1:2i], bytes = len+1
//   wdata[63:0]           per-port write data, port i at [32i +: 32], little-endian bytes
//   gnt[1:0], done[1:0]   one-cycle grant / completion pulses
//   rdata[31:0]           assembled read data of the last completed read
//   mem_a, mem_dout, mem_wr, mem_din   byte-wide external memory bus
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]          req;
  logic [1:0]          we;
  logic [2*ADDR_W-1:0] addr;
  logic [3:0]          len;
  logic [63:0]         wdata;
  logic [1:0]          gnt;
  logic [1:0]          done;
  logic [31:0]         rdata;
  logic [ADDR_W-1:0]   mem_a;
  logic [7:0]          mem_dout;
  logic                mem_wr;
  logic [7:0]          mem_din;

  modport slave (
    input  req, we, addr, len, wdata, mem_din,
    output gnt, done, rdata, mem_a, mem_dout, mem_wr
  );

  modport master (
    output req, we, addr, len, wdata, mem_din,
    input  gnt, done, rdata, mem_a, mem_dout, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one byte-wide memory bus between icache (port 0) and dcache (port 1)
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; aborts any transfer in flight
//   bus  mem_port_arbiter_if.slave (requests, grant/done pulses, rdata, memory bus)
// Parameters: ADDR_W address width, RD_LAT memory read latency (1..3)
// Optional: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise port 1 wins ties.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          len_q, len_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          k_q, k_d;
  logic                last_q, last_d;
  logic [31:0]         rdata_q, rdata_d;
  // Read-return pipeline: one slot per cycle of memory latency, carrying
  // a valid bit and the byte index whose data arrives when it exits.
  logic [RD_LAT-1:0]   pv_q, pv_d;
  logic [2*RD_LAT-1:0] pidx_q, pidx_d;

  logic                win;
  logic                cap;
  logic [1:0]          cap_idx;

  assign cap     = pv_q[RD_LAT-1];
  assign cap_idx = pidx_q[2*(RD_LAT-1) +: 2];

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    k_d     = k_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    pv_d    = '0;
    pidx_d  = '0;

`ifdef MEM_ARB_RR_EN
    win = (bus.req == 2'b11) ? ~last_q : bus.req[1];
`else
    win = bus.req[1];
`endif

    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i]          = pv_q[i-1];
      pidx_d[2*i +: 2] = pidx_q[2*(i-1) +: 2];
    end
    pidx_d[1:0] = k_q;

    if (cap) begin
      rdata_d[8*cap_idx +: 8] = bus.mem_din;
    end

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_d = ADDR;
          id_d    = win;
          last_d  = win;
          we_d    = win ? bus.we[1] : bus.we[0];
          addr_d  = win ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
          len_d   = win ? bus.len[3:2] : bus.len[1:0];
          wdata_d = win ? bus.wdata[63:32] : bus.wdata[31:0];
          k_d     = 2'd0;
          rdata_d = '0;
        end
      end
      ADDR: begin
        pv_d[0] = ~we_q;
        if (k_q == len_q) begin
          state_d = we_q ? DONE : DRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DRAIN: begin
        // The last byte leaves the pipeline exactly RD_LAT cycles after its address.
        if (cap && (cap_idx == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= 2'd0;
      wdata_q <= '0;
      k_q     <= 2'd0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      pv_q    <= '0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      pv_q    <= pv_d;
      pidx_q  <= pidx_d;
    end
  end

  // Outputs decode straight from state so reset removes mem_wr without waiting for a clock.
  // mem_a keeps addr+k after the last byte, which holds it through DRAIN and DONE.
  assign bus.gnt      = ((state_q == ADDR) && (k_q == 2'd0)) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.done     = (state_q == DONE) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata    = rdata_q;
  assign bus.mem_a    = addr_q + ADDR_W'(k_q);
  assign bus.mem_wr   = (state_q == ADDR) && we_q;
  assign bus.mem_dout = bus.mem_wr ? wdata_q[8*k_q +: 8] : 8'h00;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int RD_LAT = 3;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic [1:0]  done;
    bit          chk_bus;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    bit          chk_rd;
    logic [31:0] rd;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   last_m = 1'b1;
  ev_t  exp_q[$];
  logic [31:0] hist [3] = '{32'h0, 32'h0, 32'h0};

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_f(input logic [31:0] a);
    if (a == 32'h200) return 8'h34;
    if (a == 32'h201) return 8'h12;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Memory model: returns the byte for the address presented RD_LAT cycles earlier.
  always @(posedge clk) begin
    hist[0] <= bus.mem_a;
    hist[1] <= hist[0];
    hist[2] <= hist[1];
  end
  assign bus.mem_din = mem_f(hist[RD_LAT-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event cyc=%0d actual=skipped required=cyc%0d", cyc, e.cyc);
    end
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("gnt", 32'(bus.gnt), 32'(e.gnt));
      chk("done", 32'(bus.done), 32'(e.done));
      if (e.chk_bus) begin
        chk("mem_a", bus.mem_a, e.a);
        chk("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
        if (e.wr) chk("mem_dout", 32'(bus.mem_dout), 32'(e.dout));
      end
      if (e.chk_rd) chk("rdata", bus.rdata, e.rd);
    end else if (bus.gnt != 2'b00 || bus.done != 2'b00) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse cyc=%0d actual gnt=%b done=%b required gnt=00 done=00",
               cyc, bus.gnt, bus.done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_port(input int p, input bit w, input logic [31:0] a,
                          input logic [1:0] l, input logic [31:0] wd);
    bus.we[p]            = w;
    bus.addr[32*p +: 32] = a;
    bus.len[2*p +: 2]    = l;
    bus.wdata[32*p +: 32] = wd;
  endtask

  task automatic push_ev(input int c, input logic [1:0] g, input logic [1:0] d,
                         input logic [31:0] a, input logic w, input logic [7:0] o,
                         input bit crd, input logic [31:0] rd);
    ev_t e;
    e.cyc = c; e.gnt = g; e.done = d; e.chk_bus = 1'b1;
    e.a = a; e.wr = w; e.dout = o; e.chk_rd = crd; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Expected bus/pulse trace of one transfer granted in cycle cg; returns the done cycle.
  task automatic push_xfer(input int p, input bit w, input logic [31:0] a,
                           input logic [1:0] l, input logic [31:0] wd,
                           input int cg, output int cd);
    int          n;
    logic [1:0]  oh;
    logic [31:0] rd;
    n  = int'(l) + 1;
    oh = (p == 1) ? 2'b10 : 2'b01;
    rd = 32'h0;
    for (int k = 0; k < n; k++) begin
      push_ev(cg + k, (k == 0) ? oh : 2'b00, 2'b00, a + 32'(k), w,
              w ? wd[8*k +: 8] : 8'h00, 1'b0, 32'h0);
      rd[8*k +: 8] = mem_f(a + 32'(k));
    end
    if (!w) begin
      for (int d = 0; d < RD_LAT; d++)
        push_ev(cg + n + d, 2'b00, 2'b00, a + 32'(l), 1'b0, 8'h00, 1'b0, 32'h0);
    end
    cd = cg + n + (w ? 0 : RD_LAT);
    push_ev(cd, 2'b00, oh, a + 32'(l), 1'b0, 8'h00, !w, rd);
    last_m = (p == 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int c0, cd, cd1, cg, w;
    bus.req = 2'b00; bus.we = 2'b00; bus.addr = '0; bus.len = '0; bus.wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    push_ev(cyc, 2'b00, 2'b00, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0);
    chk("reset_mem_dout", 32'(bus.mem_dout), 32'h0);
    tick();

    // Single 4-byte write from port 1.
    c0 = cyc;
    set_port(1, 1, 32'h100, 2'd3, 32'hDDCCBBAA);
    bus.req[1] = 1'b1;
    push_xfer(1, 1, 32'h100, 2'd3, 32'hDDCCBBAA, c0 + 1, cd);
    wait_until(cd);
    bus.req[1] = 1'b0;
    tick();

    // Two-byte read from port 0, memory returns 0x34, 0x12.
    c0 = cyc;
    set_port(0, 0, 32'h200, 2'd1, 32'h0);
    bus.req[0] = 1'b1;
    push_xfer(0, 0, 32'h200, 2'd1, 32'h0, c0 + 1, cd);
    wait_until(cd);
    bus.req[0] = 1'b0;
    tick();

    // Address wrap across all-ones.
    c0 = cyc;
    set_port(1, 0, 32'hFFFFFFFE, 2'd3, 32'h0);
    bus.req[1] = 1'b1;
    push_xfer(1, 0, 32'hFFFFFFFE, 2'd3, 32'h0, c0 + 1, cd);
    wait_until(cd);
    bus.req[1] = 1'b0;
    tick();

    // Both ports request together and stay high for three grants.
    c0 = cyc;
    set_port(0, 0, 32'h300, 2'd0, 32'h0);
    set_port(1, 1, 32'h400, 2'd1, 32'h0000BEEF);
    bus.req = 2'b11;
    cg = c0 + 1;
    for (int i = 0; i < 3; i++) begin
`ifdef MEM_ARB_RR_EN
      w = last_m ? 0 : 1;
`else
      w = 1;
`endif
      if (w == 1) push_xfer(1, 1, 32'h400, 2'd1, 32'h0000BEEF, cg, cd);
      else        push_xfer(0, 0, 32'h300, 2'd0, 32'h0, cg, cd);
      wait_until(cd);
      cg = cd + 2;
    end
    bus.req = 2'b00;
    tick();

    // Late request from port 0 during port 1's write; all inputs wiggle meanwhile.
    c0 = cyc;
    set_port(1, 1, 32'h900, 2'd3, 32'h44332211);
    bus.req[1] = 1'b1;
    push_xfer(1, 1, 32'h900, 2'd3, 32'h44332211, c0 + 1, cd1);
    wait_until(c0 + 2);
    set_port(0, 0, 32'hA00, 2'd1, 32'h0);
    bus.req[0] = 1'b1;
    set_port(1, 1, 32'hBBB0, 2'd0, 32'hFFFFFFFF);
    wait_until(c0 + 3);
    set_port(0, 0, 32'hA10, 2'd2, 32'h0);
    wait_until(cd1);
    bus.req[1] = 1'b0;
    push_xfer(0, 0, 32'hA10, 2'd2, 32'h0, cd1 + 2, cd);
    wait_until(cd);
    bus.req[0] = 1'b0;
    tick();

    // Reset in the second cycle of a 4-byte write.
    c0 = cyc;
    set_port(0, 1, 32'h700, 2'd3, 32'h8899AABB);
    bus.req[0] = 1'b1;
    push_ev(c0 + 1, 2'b01, 2'b00, 32'h700, 1'b1, 8'hBB, 1'b0, 32'h0);
    wait_until(c0 + 2);
    push_ev(c0 + 2, 2'b00, 2'b00, 32'h0, 1'b0, 8'h00, 1'b1, 32'h0);
    rst = 1'b1;
    #1;
    chk("reset_mem_wr_async", 32'(bus.mem_wr), 32'h0);
    bus.req[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    last_m = 1'b1;
    tick();
    c0 = cyc;
    set_port(0, 0, 32'h800, 2'd0, 32'h0);
    bus.req[0] = 1'b1;
    push_xfer(0, 0, 32'h800, 2'd0, 32'h0, c0 + 1, cd);
    wait_until(cd);
    bus.req[0] = 1'b0;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    repeat (4) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
